// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: latches a, b, bin and produces a - b - bin LSB first, one bit per clock.
// Define SUB_OVERFLOW_EN to add the registered signed-overflow output ovf.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SUB_OVERFLOW_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam int unsigned RW = WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             brw_q, brw_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [RW-1:0]    res_q, res_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
`ifdef SUB_OVERFLOW_EN
  logic             ovf_q, ovf_d;
`endif

  logic             dbit;
  logic             brw_nx;
  logic             last_bit;

  // One full-subtractor slice on the current LSB of the shifting operands.
  always_comb begin
    dbit     = a_q[0] ^ b_q[0] ^ brw_q;
    brw_nx   = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & brw_q);
    last_bit = (cnt_q == CW'(WIDTH - 1));
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    brw_d       = brw_q;
    cnt_d       = cnt_q;
    res_d       = res_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    diff_d      = diff_q;
    bout_d      = bout_q;
`ifdef SUB_OVERFLOW_EN
    ovf_d       = ovf_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d        = a;
          b_d        = b;
          brw_d      = bin;
          cnt_d      = '0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end

      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        brw_d = brw_nx;
        // Result bits enter at the top so bit 0 ends up at the LSB after WIDTH-1 shifts.
        res_d = RW'({dbit, res_q} >> 1);
        cnt_d = CW'(cnt_q + CW'(1));
        if (last_bit) begin
          cnt_d       = '0;
          diff_d      = {dbit, res_q};
          bout_d      = brw_nx;
`ifdef SUB_OVERFLOW_EN
          ovf_d       = brw_q ^ brw_nx;
`endif
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end

      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      brw_q       <= 1'b0;
      cnt_q       <= '0;
      res_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      diff_q      <= '0;
      bout_q      <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      ovf_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      brw_q       <= brw_d;
      cnt_q       <= cnt_d;
      res_q       <= res_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      diff_q      <= diff_d;
      bout_q      <= bout_d;
`ifdef SUB_OVERFLOW_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
`ifdef SUB_OVERFLOW_EN
  assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: arithmetic reference model, per-cycle compare, directed literals.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SUB_OVERFLOW_EN
  logic         ovf;
`endif

  serial_subtractor #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout)
`ifdef SUB_OVERFLOW_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: {ovf, bout, diff} from plain unsigned and signed arithmetic.
  function automatic logic [W+1:0] ref_sub(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    logic [W:0] full;
    longint sx, sy, sr;
    logic o;
    full = {1'b0, x} - {1'b0, y} - (W+1)'(bi);
    sx = x[W-1] ? longint'(x) - (longint'(1) << W) : longint'(x);
    sy = y[W-1] ? longint'(y) - (longint'(1) << W) : longint'(y);
    sr = sx - sy - longint'(bi);
    o  = (sr < -(longint'(1) << (W-1))) || (sr > (longint'(1) << (W-1)) - 1);
    return {o, full};
  endfunction

  // Transaction-level model: accept, fixed latency of W cycles, hold until consumed.
  bit           m_rdy  = 1'b1;
  bit           m_ov   = 1'b0;
  int           m_left = 0;
  logic [W+1:0] m_pend = '0;
  logic [W-1:0] m_diff = '0;
  logic         m_bout = 1'b0;
  logic         m_ovf  = 1'b0;
  int           acc_cnt = 0;
  int           res_cnt = 0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_rdy = 1'b1; m_ov = 1'b0; m_left = 0;
      m_diff = '0; m_bout = 1'b0; m_ovf = 1'b0;
    end else if (m_rdy) begin
      if (in_valid) begin
        m_pend = ref_sub(a, b, bin);
        m_rdy  = 1'b0;
        m_left = W;
        acc_cnt++;
      end
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_ov   = 1'b1;
        m_diff = m_pend[W-1:0];
        m_bout = m_pend[W];
        m_ovf  = m_pend[W+1];
      end
    end else if (m_ov && out_ready) begin
      m_ov  = 1'b0;
      m_rdy = 1'b1;
      res_cnt++;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("in_ready",  in_ready,  m_rdy);
      chk("out_valid", out_valid, m_ov);
      chk("diff",      diff,      m_diff);
      chk("bout",      bout,      m_bout);
`ifdef SUB_OVERFLOW_EN
      chk("ovf",       ovf,       m_ovf);
`endif
    end
  end

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    int n;
    bit ok;
    n = acc_cnt;
    ok = 1'b0;
    a = x; b = y; bin = bi; in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #2;
      if (acc_cnt != n) begin ok = 1'b1; break; end
    end
    chk("accept_timeout", ok, 1'b1);
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
  endtask

  // Directed op with literal expectations and exact latency; out_ready held high.
  task automatic op_lit(input string name, input logic [W-1:0] x, input logic [W-1:0] y, input logic bi,
                        input logic [W-1:0] ed, input logic eb, input logic eo);
    send(x, y, bi);
    repeat (W-1) begin @(posedge clk); #2; end
    chk({name, "_early_valid"}, out_valid, 1'b0);
    @(posedge clk); #2;
    chk({name, "_valid"}, out_valid, 1'b1);
    chk({name, "_diff"},  diff, ed);
    chk({name, "_bout"},  bout, eb);
`ifdef SUB_OVERFLOW_EN
    chk({name, "_ovf"},   ovf,  eo);
`else
    if (eo !== 1'bx) chk({name, "_model_ovf"}, ref_sub(x, y, bi) >> W, {1'b0, eo, eb} >> 1 << 1 | 64'(eb));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int last_rise;
    int rises;
    bit prev_ov;
    int start_res;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; bin = 1'b0;
    @(posedge clk); #2;
    chk_en = 1'b1;
    chk("rst_in_ready",  in_ready,  1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_diff",      diff,      '0);
    chk("rst_bout",      bout,      1'b0);
    @(posedge clk); #2;
    rst = 1'b0;

    // Pin the reference model against hand-computed values.
    chk("model_05_03_0", ref_sub(8'h05, 8'h03, 1'b0), 10'h002);
    chk("model_00_01_0", ref_sub(8'h00, 8'h01, 1'b0), 10'h1FF);
    chk("model_00_00_1", ref_sub(8'h00, 8'h00, 1'b1), 10'h1FF);
    chk("model_80_01_0", ref_sub(8'h80, 8'h01, 1'b0), 10'h27F);
    chk("model_A0_0F_0", ref_sub(8'hA0, 8'h0F, 1'b0), 10'h091);
    chk("model_33_44_1", ref_sub(8'h33, 8'h44, 1'b1), 10'h1EE);

    out_ready = 1'b1;
    op_lit("op_05_03", 8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    op_lit("op_00_01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1, 1'b0);
    op_lit("op_00_00b", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    op_lit("op_80_01", 8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    repeat (2) @(posedge clk); #2;

    // Backpressure: result held while in_valid pulses are ignored.
    out_ready = 1'b0;
    send(8'h33, 8'h44, 1'b1);
    repeat (W) begin @(posedge clk); #2; end
    for (int k = 0; k < 5; k++) begin
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_diff",  diff, 8'hEE);
      chk("bp_bout",  bout, 1'b1);
      chk("bp_in_ready", in_ready, 1'b0);
      in_valid = ~in_valid;
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      @(posedge clk); #2;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #2;
    chk("bp_release_in_ready",  in_ready,  1'b1);
    chk("bp_release_out_valid", out_valid, 1'b0);
    chk("bp_hold_diff", diff, 8'hEE);

    // Reset during the third RUN cycle aborts the operation.
    send(8'h12, 8'h34, 1'b0);
    @(posedge clk); #2;
    @(posedge clk); #2;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    chk("abort_in_ready",  in_ready,  1'b1);
    chk("abort_out_valid", out_valid, 1'b0);
    chk("abort_diff",      diff,      '0);
    repeat (W+2) @(posedge clk); #2;
    chk("abort_no_result", out_valid, 1'b0);
    op_lit("op_A0_0F", 8'hA0, 8'h0F, 1'b0, 8'h91, 1'b0, 1'b0);
    repeat (2) @(posedge clk); #2;

    // Back-to-back with in_valid and out_ready tied high.
    in_valid = 1'b1; out_ready = 1'b1;
    last_rise = -1; rises = 0; prev_ov = 1'b0;
    for (int k = 0; k < 12*(W+2); k++) begin
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      @(posedge clk); #2;
      if (out_valid && !prev_ov) begin
        if (last_rise >= 0) chk("b2b_period", 64'(cyc - last_rise), 64'(W+2));
        last_rise = cyc;
        rises++;
      end
      prev_ov = out_valid;
    end
    chk("b2b_count_ok", rises >= 10, 1'b1);

    // Random handshakes with occasional reset.
    start_res = res_cnt;
    for (int k = 0; k < 2500; k++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 9) < 6);
      rst       = ($urandom_range(0, 399) == 0);
      a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
      @(posedge clk); #2;
    end
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (W+4) @(posedge clk); #2;
    chk("random_progress", (res_cnt - start_res) > 50, 1'b1);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
